// File: rtl/fxp_saturating_accumulator_pkg.sv
// Shared definitions for the saturating fixed-point accumulator:
// FSM state encoding and signed range limits.
package fxp_saturating_accumulator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } acc_state_e;

   // Most positive two's-complement value of an n-bit word (n <= 64).
   function automatic logic [63:0] fxp_max(input int n);
      return (64'd1 << (n - 1)) - 64'd1;
   endfunction

   // Most negative two's-complement value of an n-bit word (n <= 64).
   function automatic logic [63:0] fxp_min(input int n);
      return 64'd1 << (n - 1);
   endfunction

endpackage

// File: rtl/carry_lookahead_adder_behavioral.sv
// N-bit add/sub with generate/propagate carry chain; reports signed overflow
// and the true sign of the mathematical result. The carry-out is not exported.
module carry_lookahead_adder_behavioral #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] sum,
   output logic         ovf,
   output logic         neg
);

   logic [N-1:0] b_eff_s;
   logic [N-1:0] gen_s;
   logic [N-1:0] prop_s;

   assign b_eff_s = b ^ {N{sub}};
   assign gen_s   = a & b_eff_s;
   assign prop_s  = a ^ b_eff_s;

   // Carry chain; overflow is carry into MSB differing from carry out of MSB.
   always_comb begin
      logic carry_v;
      logic carry_msb_v;
      carry_v     = sub;
      carry_msb_v = 1'b0;
      sum         = '0;
      for (int i = 0; i < N; i++) begin
         if (i == N - 1) begin
            carry_msb_v = carry_v;
         end else begin
            carry_msb_v = carry_msb_v;
         end
         sum[i]  = prop_s[i] ^ carry_v;
         carry_v = gen_s[i] | (prop_s[i] & carry_v);
      end
      ovf = carry_v ^ carry_msb_v;
      neg = sum[N-1] ^ ovf;
   end

endmodule

// File: rtl/fxp_saturate.sv
// Clamps an adder result to the signed range using the adder's overflow and
// true-sign flags.
module fxp_saturate
   import fxp_saturating_accumulator_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [N-1:0] result,
   input  logic         ovf,
   input  logic         neg,
   output logic [N-1:0] sat_val
);

   localparam logic [N-1:0] MAX_V = N'(fxp_max(N));
   localparam logic [N-1:0] MIN_V = N'(fxp_min(N));

   // Select pass-through or the limit matching the true sign.
   always_comb begin
      sat_val = result;
      if (!ovf) begin
         sat_val = result;
      end else if (neg) begin
         sat_val = MIN_V;
      end else begin
         sat_val = MAX_V;
      end
   end

endmodule

// File: rtl/fxp_saturating_accumulator.sv
// Packet-oriented saturating accumulator: adds/subtracts each accepted beat
// into a running sum and presents one saturated result per in_last packet.
module fxp_saturating_accumulator
   import fxp_saturating_accumulator_pkg::*;
#(
   parameter int N     = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic             in_sub,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_data,
   output logic             out_sat,
   output logic [CNT_W-1:0] out_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   acc_state_e       state_q, state_d;
   logic [N-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             sat_q, sat_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic [N-1:0]     sum_s;
   logic [N-1:0]     sat_val_s;
   logic             ovf_s;
   logic             neg_s;
   logic             accept_s;

   carry_lookahead_adder_behavioral #(.N(N)) u_adder (
      .a   (acc_q),
      .b   (in_data),
      .sub (in_sub),
      .sum (sum_s),
      .ovf (ovf_s),
      .neg (neg_s)
   );

   fxp_saturate #(.N(N)) u_sat (
      .result  (sum_s),
      .ovf     (ovf_s),
      .neg     (neg_s),
      .sat_val (sat_val_s)
   );

   assign accept_s = in_valid & in_ready_q;

   // Next-state and datapath; in_ready/out_valid are derived from the next state
   // so both are registered and already correct in the first cycle of a state.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      sat_d   = sat_q;
      case (state_q)
         ST_IDLE, ST_ACC: begin
            if (accept_s) begin
               acc_d   = sat_val_s;
               count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
               sat_d   = sat_q | ovf_s;
               state_d = in_last ? ST_DONE : ST_ACC;
            end else begin
               state_d = state_q;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               acc_d   = '0;
               count_d = '0;
               sat_d   = 1'b0;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            acc_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
      in_ready_d  = (state_d != ST_DONE);
      out_valid_d = (state_d == ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         count_q     <= '0;
         sat_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         sat_q       <= sat_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = acc_q;
   assign out_sat   = sat_q;
   assign out_count = count_q;

endmodule

// File: tb/tb_fxp_saturating_accumulator.sv
// Directed bench: vector table of packets plus hand-written stall, reset and
// counter-saturation sequences. A second instance uses a 2-bit beat counter.
module tb_fxp_saturating_accumulator;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_sub;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_sat;
   logic [7:0]  out_count;

   logic        in_ready2;
   logic        out_valid2;
   logic [15:0] out_data2;
   logic        out_sat2;
   logic [1:0]  out_count2;

   int checks;
   int failures;

   fxp_saturating_accumulator #(.N(16), .CNT_W(8)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sub    (in_sub),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .out_count (out_count)
   );

   fxp_saturating_accumulator #(.N(16), .CNT_W(2)) u_dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready2),
      .in_data   (in_data),
      .in_sub    (in_sub),
      .in_last   (in_last),
      .out_valid (out_valid2),
      .out_ready (out_ready),
      .out_data  (out_data2),
      .out_sat   (out_sat2),
      .out_count (out_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]       nbeats;
      logic [3:0][15:0] data;
      logic [3:0]       sub;
      logic [15:0]      exp_data;
      logic             exp_sat;
      logic [7:0]       exp_count;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the beat was accepted.
   task automatic beat(input logic [15:0] d, input logic s, input logic l);
      int t;
      in_valid = 1'b1;
      in_data  = d;
      in_sub   = s;
      in_last  = l;
      t = 0;
      while (!in_ready && t < 64) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL beat_timeout actual=in_ready_low expected=in_ready_high");
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'h0000;
      in_sub   = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic collect(input string name, input logic [15:0] ed, input logic es, input logic [7:0] ec);
      check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({name, "_data"},  {16'd0, out_data},  {16'd0, ed});
      check({name, "_sat"},   {31'd0, out_sat},   {31'd0, es});
      check({name, "_count"}, {24'd0, out_count}, {24'd0, ec});
      check({name, "_done_ready"}, {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, "_released"}, {31'd0, out_valid}, 32'd0);
      check({name, "_cleared"},  {24'd0, out_count}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0000;
      in_sub    = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      vecs[0] = '{3'd3, {16'h0000, 16'h0080, 16'h0200, 16'h0100}, 4'b0100, 16'h0280, 1'b0, 8'd3};
      vecs[1] = '{3'd2, {16'h0000, 16'h0000, 16'h2000, 16'h7000}, 4'b0000, 16'h7FFF, 1'b1, 8'd2};
      vecs[2] = '{3'd2, {16'h0000, 16'h0000, 16'hFFFF, 16'h8000}, 4'b0000, 16'h8000, 1'b1, 8'd2};
      vecs[3] = '{3'd1, {16'h0000, 16'h0000, 16'h0000, 16'h8000}, 4'b0001, 16'h7FFF, 1'b1, 8'd1};
      vecs[4] = '{3'd3, {16'h0000, 16'h0001, 16'h0001, 16'h7FFF}, 4'b0100, 16'h7FFE, 1'b1, 8'd3};
      vecs[5] = '{3'd2, {16'h0000, 16'h0000, 16'h0003, 16'hFFFB}, 4'b0001, 16'h0008, 1'b0, 8'd2};
      vecs[6] = '{3'd2, {16'h0000, 16'h0000, 16'h0001, 16'h8000}, 4'b0010, 16'h8000, 1'b1, 8'd2};
      vecs[7] = '{3'd4, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 4'b0000, 16'h000A, 1'b0, 8'd4};

      #2;
      check("reset_valid", {31'd0, out_valid}, 32'd0);
      check("reset_data",  {16'd0, out_data},  32'd0);
      check("reset_count", {24'd0, out_count}, 32'd0);
      check("reset_sat",   {31'd0, out_sat},   32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("ready_after_reset", {31'd0, in_ready}, 32'd1);

      for (int v = 0; v < 8; v++) begin
         for (int b = 0; b < int'(vecs[v].nbeats); b++) begin
            beat(vecs[v].data[b], vecs[v].sub[b], (b == int'(vecs[v].nbeats) - 1));
         end
         collect($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_sat, vecs[v].exp_count);
      end

      // Stall in DONE with the next beat already presented.
      beat(16'h0100, 1'b0, 1'b1);
      in_valid = 1'b1;
      in_data  = 16'h0011;
      in_sub   = 1'b0;
      in_last  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("stall%0d_ready", k), {31'd0, in_ready},  32'd0);
         check($sformatf("stall%0d_valid", k), {31'd0, out_valid}, 32'd1);
         check($sformatf("stall%0d_data", k),  {16'd0, out_data},  32'h0100);
         check($sformatf("stall%0d_count", k), {24'd0, out_count}, 32'd1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("stall_release_valid", {31'd0, out_valid}, 32'd0);
      check("stall_release_ready", {31'd0, in_ready},  32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 16'h0000;
      collect("pending", 16'h0011, 1'b0, 8'd1);

      // Asynchronous reset in the middle of a packet.
      beat(16'h0100, 1'b0, 1'b0);
      beat(16'h0200, 1'b0, 1'b0);
      check("partial_data",  {16'd0, out_data},  32'h0300);
      check("partial_count", {24'd0, out_count}, 32'd2);
      rst_n = 1'b0;
      #1;
      check("midrst_data",  {16'd0, out_data},  32'd0);
      check("midrst_count", {24'd0, out_count}, 32'd0);
      check("midrst_sat",   {31'd0, out_sat},   32'd0);
      check("midrst_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_ready", {31'd0, in_ready}, 32'd1);
      beat(16'h0010, 1'b0, 1'b1);
      collect("after_rst", 16'h0010, 1'b0, 8'd1);

      // Five beats of +1: the 2-bit counter instance must stop at 3.
      for (int b = 0; b < 5; b++) begin
         beat(16'h0001, 1'b0, (b == 4));
      end
      check("cnt2_valid", {31'd0, out_valid2}, 32'd1);
      check("cnt2_data",  {16'd0, out_data2},  32'h0005);
      check("cnt2_count", {30'd0, out_count2}, 32'd3);
      check("cnt2_sat",   {31'd0, out_sat2},   32'd0);
      collect("cnt8", 16'h0005, 1'b0, 8'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
